// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//   Converts a raster pixel stream into 3x3 neighbourhood windows for the
//   window-based kernels (dilation, erosion, ...). Two line buffers hold the
//   previous two rows, and a 3x3 tap register holds the last three columns.
//   One window is produced for each accepted pixel whose centre is an
//   interior pixel.
//
//   Optional feature macro: BORDER_ZERO_EN
//     defined   : one window per accepted pixel. Taps that fall above row 0
//                 or left of column 0 are forced to zero. Right and bottom
//                 edges are not padded.
//     undefined : interior-only windows, with no masking logic.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   pixel_in      raster pixel, row-major, top-left first
//   pixel_valid   pixel_in accepted this cycle (no backpressure)
//   sof           start of frame, only honoured together with pixel_valid
//   window_out    9 taps; tap k = 3*r+c at [k*DATA_WIDTH +: DATA_WIDTH]
//                 (r=0 is row y-2, c=0 is column x-2, tap 8 is the newest)
//   window_valid  one-cycle pulse qualifying window_out/win_x/win_y
//   win_x, win_y  coordinates of the newest (bottom-right) tap
//   frame_done    one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    input  logic                      pixel_valid,
    input  logic                      sof,
    output logic [9*DATA_WIDTH-1:0]   window_out,
    output logic                      window_valid,
    output logic [15:0]               win_x,
    output logic [15:0]               win_y,
    output logic                      frame_done
);

    localparam int          AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    logic [15:0]           x_cnt;
    logic [15:0]           y_cnt;
    logic [15:0]           cur_x;
    logic [15:0]           cur_y;
    logic [15:0]           nxt_x;
    logic [15:0]           nxt_y;
    logic                  last_pix;
    logic                  win_hit;
    logic [AW-1:0]         lb_addr;

    // lb1 holds row y-1, lb0 holds row y-2. These arrays are never cleared:
    // any stale content only reaches taps that are masked or never reported.
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;

    logic [DATA_WIDTH-1:0] tap_q [9];
    logic [DATA_WIDTH-1:0] tap_d [9];
    logic [9*DATA_WIDTH-1:0] win_d;

    always_comb begin
        // sof forces the accepted pixel to (0,0) regardless of the counters.
        cur_x    = (pixel_valid && sof) ? 16'd0 : x_cnt;
        cur_y    = (pixel_valid && sof) ? 16'd0 : y_cnt;
        lb_addr  = cur_x[AW-1:0];
        lb0_rd   = lb0[lb_addr];
        lb1_rd   = lb1[lb_addr];

        last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
        if (cur_x == X_LAST) begin
            nxt_x = 16'd0;
            nxt_y = (cur_y == Y_LAST) ? 16'd0 : cur_y + 16'd1;
        end else begin
            nxt_x = cur_x + 16'd1;
            nxt_y = cur_y;
        end

        // Shift columns left; the new right-hand column is {row y-2, y-1, y}.
        for (int r = 0; r < 3; r++) begin
            tap_d[3*r]     = tap_q[3*r+1];
            tap_d[3*r+1]   = tap_q[3*r+2];
        end
        tap_d[2] = lb0_rd;
        tap_d[5] = lb1_rd;
        tap_d[8] = pixel_in;

        win_d = '0;
        for (int k = 0; k < 9; k++) begin
`ifdef BORDER_ZERO_EN
            // Tap k sits at row y-2+k/3 and column x-2+k%3; zero it if either
            // index would be negative.
            if ((cur_y >= 16'(2 - k/3)) && (cur_x >= 16'(2 - k%3)))
                win_d[k*DATA_WIDTH +: DATA_WIDTH] = tap_d[k];
`else
            win_d[k*DATA_WIDTH +: DATA_WIDTH] = tap_d[k];
`endif
        end

`ifdef BORDER_ZERO_EN
        win_hit = 1'b1;
`else
        // x>=2 also guarantees that no column from the previous line is present.
        win_hit = (cur_x >= 16'd2) && (cur_y >= 16'd2);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt        <= '0;
            y_cnt        <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            win_x        <= '0;
            win_y        <= '0;
            frame_done   <= 1'b0;
            for (int k = 0; k < 9; k++) tap_q[k] <= '0;
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (pixel_valid) begin
                x_cnt      <= nxt_x;
                y_cnt      <= nxt_y;
                frame_done <= last_pix;
                for (int k = 0; k < 9; k++) tap_q[k] <= tap_d[k];
                // Outputs only move when a window is reported, so they hold otherwise.
                if (win_hit) begin
                    window_out   <= win_d;
                    window_valid <= 1'b1;
                    win_x        <= cur_x;
                    win_y        <= cur_y;
                end
            end
        end
    end

    // Read-before-write: the current column's old values feed tap_d this cycle.
    always_ff @(posedge clk) begin
        if (pixel_valid && !rst) begin
            lb0[lb_addr] <= lb1_rd;
            lb1[lb_addr] <= pixel_in;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     pixel_in = '0;
    logic              pixel_valid = 1'b0;
    logic              sof = 1'b0;
    logic [9*DW-1:0]   window_out;
    logic              window_valid;
    logic [15:0]       win_x;
    logic [15:0]       win_y;
    logic              frame_done;

    always #5 clk = ~clk;

    window_gen_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .sof(sof), .window_out(window_out), .window_valid(window_valid),
        .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the frame as a 2D pixel grid plus the raster position.
    logic [DW-1:0]   img [H][W];
    int              mx = 0;
    int              my = 0;
    logic [9*DW-1:0] e_win = '0;
    logic [15:0]     e_x = '0;
    logic [15:0]     e_y = '0;
    logic            e_valid = 1'b0;
    logic            e_done = 1'b0;

    typedef struct packed {
        logic [15:0]     x;
        logic [15:0]     y;
        logic [9*DW-1:0] win;
    } cap_t;
    cap_t cap_q[$];
    int   done_cnt = 0;

    typedef struct {
        int x;
        int y;
        int t[9];
    } ref_t;
    ref_t tbl[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic [DW-1:0] p);
        rst = r; pixel_valid = v; sof = s; pixel_in = p;
        @(posedge clk);
        if (r) begin
            mx = 0; my = 0;
            e_valid = 1'b0; e_done = 1'b0; e_win = '0; e_x = '0; e_y = '0;
        end else begin
            e_valid = 1'b0;
            e_done  = 1'b0;
            if (v) begin
                if (s) begin mx = 0; my = 0; end
                img[my][mx] = p;
                if (mx >= 2 && my >= 2) begin
                    e_valid = 1'b1;
                    e_x = 16'(mx);
                    e_y = 16'(my);
                    for (int k = 0; k < 9; k++)
                        e_win[k*DW +: DW] = img[my-2+k/3][mx-2+k%3];
                end
                if (mx == W-1) begin
                    mx = 0;
                    if (my == H-1) begin my = 0; e_done = 1'b1; end
                    else my++;
                end else mx++;
            end
        end
        #1;
        check("window_valid", 128'(window_valid), 128'(e_valid));
        check("frame_done",   128'(frame_done),   128'(e_done));
        check("window_out",   128'(window_out),   128'(e_win));
        check("win_x",        128'(win_x),        128'(e_x));
        check("win_y",        128'(win_y),        128'(e_y));
        if (window_valid) cap_q.push_back('{x: win_x, y: win_y, win: window_out});
        if (frame_done) done_cnt++;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < W*H; i++) begin
            step(1'b0, 1'b1, i == 0, DW'(i + 1));
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, DW'($urandom));
        end
    endtask

    task automatic check_windows(input string name, input int frames);
        logic [9*DW-1:0] w;
        check({name, "_count"}, 128'(cap_q.size()), 128'(4*frames));
        for (int i = 0; i < cap_q.size() && i < 4*frames; i++) begin
            for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(tbl[i%4].t[k]);
            check({name, "_tbl_x"},   128'(cap_q[i].x),   128'(tbl[i%4].x));
            check({name, "_tbl_y"},   128'(cap_q[i].y),   128'(tbl[i%4].y));
            check({name, "_tbl_win"}, 128'(cap_q[i].win), 128'(w));
        end
        cap_q.delete();
    endtask

    initial begin
        tbl[0] = '{x: 2, y: 2, t: '{1, 2, 3, 5, 6, 7, 9, 10, 11}};
        tbl[1] = '{x: 3, y: 2, t: '{2, 3, 4, 6, 7, 8, 10, 11, 12}};
        tbl[2] = '{x: 2, y: 3, t: '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
        tbl[3] = '{x: 3, y: 3, t: '{6, 7, 8, 10, 11, 12, 14, 15, 16}};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b0, '0);

        // 1: continuous frame
        cap_q.delete(); done_cnt = 0;
        send_frame(0);
        step(1'b0, 1'b0, 1'b0, '0);
        check_windows("t1", 1);
        check("t1_done_cnt", 128'(done_cnt), 128'(1));

        // 2: valid every other cycle
        done_cnt = 0;
        send_frame(1);
        check_windows("t2", 1);
        check("t2_done_cnt", 128'(done_cnt), 128'(1));

        // 3: two frames back-to-back, then an idle cycle
        done_cnt = 0;
        send_frame(0);
        send_frame(0);
        step(1'b0, 1'b0, 1'b0, '0);
        check_windows("t3", 2);
        check("t3_done_cnt", 128'(done_cnt), 128'(2));

        // 4: partial frame of 6 pixels, then sof restart
        done_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i == 0, DW'(100 + i));
        step(1'b0, 1'b0, 1'b1, 8'hAA);   // sof without valid is ignored
        send_frame(0);
        step(1'b0, 1'b0, 1'b0, '0);
        check_windows("t4", 1);
        check("t4_done_cnt", 128'(done_cnt), 128'(1));

        // 5: reset asserted during pixel 10, then a fresh frame
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, i == 0, DW'(i + 1));
        step(1'b1, 1'b1, 1'b0, DW'(10));
        check("t5_rst_valid", 128'(window_valid), 128'(0));
        check("t5_rst_win",   128'(window_out),   128'(0));
        step(1'b0, 1'b1, 1'b0, DW'(1));  // no sof: reset alone must put this at (0,0)
        for (int i = 1; i < W*H; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 1));
        step(1'b0, 1'b0, 1'b0, '0);
        check_windows("t5", 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 39) == 0,
                 DW'($urandom));
        end
        cap_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
